// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse definitions: command/response bytes,
// init/stream state encoding and small lookup helpers.
package ps2_pkg;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] ACK        = 8'hFA;
    localparam logic [7:0] BAT_OK     = 8'hAA;
    localparam logic [7:0] ID_MOUSE   = 8'h00;

    typedef enum logic [3:0] {
        SEND_RST,
        WAIT_ACK1,
        WAIT_BAT,
        WAIT_ID,
        SEND_EN,
        WAIT_ACK2,
        B0,
        B1,
        B2,
        FAIL
    } ms_state_t;

    function automatic logic [7:0] expected_rsp(ms_state_t s);
        case (s)
            WAIT_BAT: return BAT_OK;
            WAIT_ID:  return ID_MOUSE;
            default:  return ACK;
        endcase
    endfunction

    function automatic ms_state_t wait_next(ms_state_t s);
        case (s)
            WAIT_ACK1: return WAIT_BAT;
            WAIT_BAT:  return WAIT_ID;
            WAIT_ID:   return SEND_EN;
            default:   return B0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_timeout.sv
// Reloadable down-counter; expired is high once CYCLES-1
// enabled cycles have elapsed since the last clear.
module ps2_timeout #(
    parameter int unsigned CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

    logic [W-1:0] count;

    // Reload on clear, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= LOAD;
        end else if (clr) begin
            count <= LOAD;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/ps2_mouse_stream.sv
// PS/2 mouse init handshake and 3-byte stream packet decoder
// sitting on top of the PS/2 controller byte interface.
module ps2_mouse_stream
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] tx_data,
    output logic       tx_write,
    output logic       init_done,
    output logic       init_err,
    output logic       btn_l,
    output logic       btn_r,
    output logic       btn_m,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic       pkt_valid
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    ms_state_t   state;
    logic [RW-1:0] retry;
    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic        tmo;
    logic        in_send;
    logic        tmr_clr;
    logic        last_try;

    // Every state change is caused by a send, a byte or an expiry,
    // so clearing on those covers all transitions.
    assign in_send  = (state == SEND_RST) || (state == SEND_EN);
    assign tmr_clr  = rx_done | tmo | in_send;
    assign last_try = (32'(retry) + 32'd1) >= MAX_RETRY;

    ps2_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (1'b1),
        .expired (tmo)
    );

    // Init handshake, retry policy and packet assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEND_RST;
            retry     <= '0;
            byte0     <= '0;
            byte1     <= '0;
            tx_data   <= '0;
            tx_write  <= 1'b0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            btn_l     <= 1'b0;
            btn_r     <= 1'b0;
            btn_m     <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            x_ovf     <= 1'b0;
            y_ovf     <= 1'b0;
            pkt_valid <= 1'b0;
        end else begin
            tx_write  <= 1'b0;
            pkt_valid <= 1'b0;
            unique case (state)
                SEND_RST: begin
                    tx_data  <= CMD_RESET;
                    tx_write <= 1'b1;
                    state    <= WAIT_ACK1;
                end
                SEND_EN: begin
                    tx_data  <= CMD_ENABLE;
                    tx_write <= 1'b1;
                    state    <= WAIT_ACK2;
                end
                WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2: begin
                    if (rx_done && rx_data == expected_rsp(state)) begin
                        state <= wait_next(state);
                        if (state == WAIT_ACK2) begin
                            init_done <= 1'b1;
                            retry     <= '0;
                        end
                    end else if (rx_done || tmo) begin
                        if (last_try) begin
                            state     <= FAIL;
                            init_err  <= 1'b1;
                            init_done <= 1'b0;
                        end else begin
                            retry <= retry + 1'b1;
                            state <= SEND_RST;
                        end
                    end
                end
                B0: begin
                    if (rx_done && rx_data[3]) begin
                        byte0 <= rx_data;
                        state <= B1;
                    end
                end
                B1: begin
                    if (rx_done) begin
                        byte1 <= rx_data;
                        state <= B2;
                    end else if (tmo) begin
                        state <= B0;
                    end
                end
                B2: begin
                    if (rx_done) begin
                        btn_l     <= byte0[0];
                        btn_r     <= byte0[1];
                        btn_m     <= byte0[2];
                        x_ovf     <= byte0[6];
                        y_ovf     <= byte0[7];
                        dx        <= {byte0[4], byte1};
                        dy        <= {byte0[5], rx_data};
                        pkt_valid <= 1'b1;
                        state     <= B0;
                    end else if (tmo) begin
                        state <= B0;
                    end
                end
                FAIL: begin
                    init_err  <= 1'b1;
                    init_done <= 1'b0;
                end
                default: state <= SEND_RST;
            endcase
        end
    end

endmodule
